// File: rtl/lock_manager_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lock_manager_pkg
// Description : Shared command/ack codes and field positions for lock_manager
// Revision    : 1.0 - initial release
// ============================================================================
package lock_manager_pkg;

  localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
  localparam logic [7:0] CMD_UNLOCK_CODE = 8'h06;

  localparam int LOCK_ID_L    = 8;
  localparam int LOCK_ID_H    = 15;
  localparam int LOCK_ID_BITS = LOCK_ID_H - LOCK_ID_L + 1;

  localparam logic [7:0] ACK_OK     = 8'h01;
  localparam logic [7:0] ACK_REJECT = 8'h00;

  localparam int ACK_LOCKID_L     = 8;
  localparam int ACK_LOCKID_H     = 15;
  localparam int LOCK_NUM_DEFAULT = 256;

  // True when a lock id addresses an implemented slot
  function automatic logic id_in_range(input logic [LOCK_ID_BITS-1:0] id, input int num);
    return int'({24'd0, id}) < num;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lock_table.sv
`default_nettype none
// ============================================================================
// Module      : lock_table
// Description : Per-slot busy flag and owner id storage; registered write,
//               combinational read by lock id
// Revision    : 1.0 - initial release
// ============================================================================
module lock_table
  import lock_manager_pkg::*;
#(
  parameter int NUM_LOCKS = LOCK_NUM_DEFAULT,
  parameter int ACC_BITS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LOCK_ID_BITS-1:0] rd_id,
  output logic                    rd_busy,
  output logic [ACC_BITS-1:0]     rd_owner,
  input  logic                    wr_en,
  input  logic [LOCK_ID_BITS-1:0] wr_id,
  input  logic                    wr_busy,
  input  logic [ACC_BITS-1:0]     wr_owner
);

  // Slot index width; ids beyond NUM_LOCKS are filtered before indexing
  localparam int IDX_W = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;

  logic [NUM_LOCKS-1:0] r_busy;
  logic [ACC_BITS-1:0]  r_owner [NUM_LOCKS];

  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_rd_idx = rd_id[IDX_W-1:0];
  assign w_wr_idx = wr_id[IDX_W-1:0];

  // Read the addressed slot; out-of-range ids read as free with owner zero
  always_comb begin
    rd_busy  = 1'b0;
    rd_owner = '0;
    if (id_in_range(rd_id, NUM_LOCKS)) begin
      rd_busy  = r_busy[w_rd_idx];
      rd_owner = r_owner[w_rd_idx];
    end
  end

  // Clear all slots on reset, otherwise apply a single-slot update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      for (int i = 0; i < NUM_LOCKS; i++) begin
        r_owner[i] <= '0;
      end
    end else if (wr_en && id_in_range(wr_id, NUM_LOCKS)) begin
      r_busy[w_wr_idx]  <= wr_busy;
      r_owner[w_wr_idx] <= wr_owner;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lock_manager.sv
`default_nettype none
// ============================================================================
// Module      : lock_manager
// Description : Stream-driven lock arbiter: accepts LOCK/UNLOCK commands from
//               accelerators, maintains ownership and returns LOCK acks
// Revision    : 1.0 - initial release
// ============================================================================
module lock_manager
  import lock_manager_pkg::*;
#(
  parameter int NUM_LOCKS = LOCK_NUM_DEFAULT,
  parameter int ACC_BITS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [63:0]         cmd_in_tdata,
  input  logic                cmd_in_tvalid,
  output logic                cmd_in_tready,
  input  logic [ACC_BITS-1:0] cmd_in_tid,
  output logic [63:0]         ack_out_tdata,
  output logic                ack_out_tvalid,
  input  logic                ack_out_tready,
  output logic [ACC_BITS-1:0] ack_out_tdest,
  output logic [8:0]          locked_count,
  output logic                err_pulse
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [1:0]              r_state;
  logic [7:0]              r_cmd_type;
  logic [LOCK_ID_BITS-1:0] r_lock_id;
  logic [ACC_BITS-1:0]     r_tid;
  logic [7:0]              r_ack_code;
  logic [LOCK_ID_BITS-1:0] r_ack_id;
  logic [ACC_BITS-1:0]     r_ack_dest;
  logic [8:0]              r_locked_count;

  logic                w_tbl_busy;
  logic [ACC_BITS-1:0] w_tbl_owner;
  logic                w_exec;
  logic                w_is_lock;
  logic                w_is_unlock;
  logic                w_in_range;
  logic                w_grant;
  logic                w_free;
  logic                w_err;
  logic                w_accept;
  logic [63:0]         w_ack_word;
  logic                w_unused_tdata;

  // Payload bits above the lock id carry no meaning for this block
  assign w_unused_tdata = ^cmd_in_tdata[63:16];

  lock_table #(
    .NUM_LOCKS (NUM_LOCKS),
    .ACC_BITS  (ACC_BITS)
  ) u_lock_table (
    .clk      (clk),
    .rst      (rst),
    .rd_id    (r_lock_id),
    .rd_busy  (w_tbl_busy),
    .rd_owner (w_tbl_owner),
    .wr_en    (w_grant | w_free),
    .wr_id    (r_lock_id),
    .wr_busy  (w_grant),
    .wr_owner (w_grant ? r_tid : {ACC_BITS{1'b0}})
  );

  // Decode the registered command against the current slot contents
  always_comb begin
    w_exec      = (r_state == ST_EXEC);
    w_is_lock   = (r_cmd_type == CMD_LOCK_CODE);
    w_is_unlock = (r_cmd_type == CMD_UNLOCK_CODE);
    w_in_range  = id_in_range(r_lock_id, NUM_LOCKS);
    w_grant     = w_exec && w_is_lock && w_in_range && !w_tbl_busy;
    w_free      = w_exec && w_is_unlock && w_in_range && w_tbl_busy && (w_tbl_owner == r_tid);
    w_err       = w_exec && ((w_is_lock && !w_in_range) ||
                             (w_is_unlock && !w_free) ||
                             (!w_is_lock && !w_is_unlock));
  end

  // Assemble the ack word; everything above the id echo stays zero
  always_comb begin
    w_ack_word = '0;
    w_ack_word[7:0] = r_ack_code;
    w_ack_word[ACK_LOCKID_H:ACK_LOCKID_L] = r_ack_id;
  end

  // Handshake-facing outputs are forced low while reset is asserted
  assign w_accept       = cmd_in_tready && cmd_in_tvalid;
  assign cmd_in_tready  = !rst && (r_state == ST_IDLE);
  assign ack_out_tvalid = !rst && (r_state == ST_ACK);
  assign err_pulse      = !rst && w_err;
  assign ack_out_tdata  = w_ack_word;
  assign ack_out_tdest  = r_ack_dest;
  assign locked_count   = r_locked_count;

  // Command sequencing: accept, execute, then optionally hold an ack
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) r_state <= ST_EXEC;
        ST_EXEC: r_state <= w_is_lock ? ST_ACK : ST_IDLE;
        ST_ACK:  if (ack_out_tready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Capture the command on accept and the ack fields when a LOCK executes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_type <= '0;
      r_lock_id  <= '0;
      r_tid      <= '0;
      r_ack_code <= '0;
      r_ack_id   <= '0;
      r_ack_dest <= '0;
    end else begin
      if (w_accept) begin
        r_cmd_type <= cmd_in_tdata[7:0];
        r_lock_id  <= cmd_in_tdata[LOCK_ID_H:LOCK_ID_L];
        r_tid      <= cmd_in_tid;
      end
      if (w_exec && w_is_lock) begin
        r_ack_code <= w_grant ? ACK_OK : ACK_REJECT;
        r_ack_id   <= r_lock_id;
        r_ack_dest <= r_tid;
      end
    end
  end

  // Held-lock counter moves in step with the table update and saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      r_locked_count <= '0;
    end else if (w_grant && (r_locked_count < 9'(NUM_LOCKS))) begin
      r_locked_count <= r_locked_count + 9'd1;
    end else if (w_free && (r_locked_count != 9'd0)) begin
      r_locked_count <= r_locked_count - 9'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lock_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_lock_manager
// Description : Self-checking bench for lock_manager with a lock-semantics
//               model and per-cycle output comparison
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_manager;

  localparam int NL = 16;
  localparam int AB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   cmd_in_tdata;
  logic          cmd_in_tvalid;
  logic          cmd_in_tready;
  logic [AB-1:0] cmd_in_tid;
  logic [63:0]   ack_out_tdata;
  logic          ack_out_tvalid;
  logic          ack_out_tready;
  logic [AB-1:0] ack_out_tdest;
  logic [8:0]    locked_count;
  logic          err_pulse;

  always #5 clk = ~clk;

  lock_manager #(.NUM_LOCKS(NL), .ACC_BITS(AB)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_in_tdata   (cmd_in_tdata),
    .cmd_in_tvalid  (cmd_in_tvalid),
    .cmd_in_tready  (cmd_in_tready),
    .cmd_in_tid     (cmd_in_tid),
    .ack_out_tdata  (ack_out_tdata),
    .ack_out_tvalid (ack_out_tvalid),
    .ack_out_tready (ack_out_tready),
    .ack_out_tdest  (ack_out_tdest),
    .locked_count   (locked_count),
    .err_pulse      (err_pulse)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit  m_busy [256];
  int  m_owner[256];
  int  m_count = 0;
  int  m_phase = 0;   // 0 waiting for a command, 1 executing, 2 ack outstanding
  bit  m_live  = 0;
  bit  p_err, p_is_lock, p_grant, p_free;
  int  p_id, p_tid, p_code;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin m_busy[i] = 0; m_owner[i] = 0; end
      m_count = 0;
      m_phase = 0;
      m_live  = 1;
    end else if (m_live) begin
      if (m_phase == 0) begin
        if (cmd_in_tvalid) begin
          int t;
          t = int'(cmd_in_tdata[7:0]);
          p_id = int'(cmd_in_tdata[15:8]);
          p_tid = int'(cmd_in_tid);
          p_is_lock = (t == 4);
          p_grant = 0; p_free = 0; p_code = 0;
          if (t == 4) begin
            p_grant = (p_id < NL) && !m_busy[p_id];
            p_code  = p_grant ? 1 : 0;
            p_err   = !(p_id < NL);
          end else if (t == 6) begin
            p_free = (p_id < NL) && m_busy[p_id] && (m_owner[p_id] == p_tid);
            p_err  = !p_free;
          end else begin
            p_err = 1;
          end
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (p_grant) begin m_busy[p_id] = 1; m_owner[p_id] = p_tid; m_count++; end
        if (p_free)  begin m_busy[p_id] = 0; m_owner[p_id] = 0;     m_count--; end
        m_phase = p_is_lock ? 2 : 0;
      end else begin
        if (ack_out_tready) m_phase = 0;
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      chk("tready", cmd_in_tready, !rst && m_phase == 0);
      chk("tvalid", ack_out_tvalid, !rst && m_phase == 2);
      chk("err_pulse", err_pulse, !rst && m_phase == 1 && p_err);
      chk("locked_count", locked_count, m_count);
      if (!rst && m_phase == 2) begin
        chk("ack_tdata", ack_out_tdata, {48'd0, 8'(p_id), 8'(p_code)});
        chk("ack_tdest", ack_out_tdest, p_tid);
      end
    end
  end

  // Observation counters used by the literal checks
  int          ack_cnt = 0;
  int          err_cnt = 0;
  logic [63:0] last_data = '0;
  logic [AB-1:0] last_dest = '0;

  always @(negedge clk) begin
    if (ack_out_tvalid && ack_out_tready) begin
      ack_cnt++;
      last_data = ack_out_tdata;
      last_dest = ack_out_tdest;
    end
    if (err_pulse) err_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] t, input logic [7:0] id, input logic [AB-1:0] tid);
    bit ok = 0;
    cmd_in_tdata  = {48'hDEAD_BEEF_0000, id, t};
    cmd_in_tid    = tid;
    cmd_in_tvalid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (cmd_in_tready) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: tready stayed %b, required 1", cmd_in_tready);
    end
    @(posedge clk); #1;
    cmd_in_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (ack_out_tvalid) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ack_timeout: tvalid stayed %b, required 1", ack_out_tvalid);
    end
  endtask

  logic [63:0]   hold_data;
  logic [AB-1:0] hold_dest;
  int            acks_before;

  initial begin
    rst = 1'b1; cmd_in_tvalid = 1'b0; cmd_in_tdata = '0; cmd_in_tid = '0;
    ack_out_tready = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tready", cmd_in_tready, 1);
    chk("rst_tvalid", ack_out_tvalid, 0);
    chk("rst_tdata", ack_out_tdata, 64'h0);
    chk("rst_tdest", ack_out_tdest, 0);
    chk("rst_count", locked_count, 0);
    @(posedge clk); #1;

    // Grant, contention, illegal unlock, legal unlock, re-grant
    send(8'h04, 8'd5, 4'd2); idle(4);
    chk("lk5_a2_data", last_data, 64'h0501); chk("lk5_a2_dest", last_dest, 2);
    chk("lk5_a2_cnt", locked_count, 1);     chk("lk5_a2_acks", ack_cnt, 1);
    send(8'h04, 8'd5, 4'd3); idle(4);
    chk("lk5_a3_data", last_data, 64'h0500); chk("lk5_a3_dest", last_dest, 3);
    chk("lk5_a3_cnt", locked_count, 1);
    send(8'h06, 8'd5, 4'd3); idle(3);
    chk("ul5_a3_err", err_cnt, 1); chk("ul5_a3_cnt", locked_count, 1); chk("ul5_a3_acks", ack_cnt, 2);
    send(8'h06, 8'd5, 4'd2); idle(3);
    chk("ul5_a2_cnt", locked_count, 0); chk("ul5_a2_acks", ack_cnt, 2); chk("ul5_a2_err", err_cnt, 1);
    send(8'h04, 8'd5, 4'd3); idle(4);
    chk("relk5_data", last_data, 64'h0501); chk("relk5_dest", last_dest, 3);

    // Ack back-pressure for 10 cycles
    ack_out_tready = 1'b0;
    send(8'h04, 8'd7, 4'd1);
    wait_valid();
    hold_data = ack_out_tdata; hold_dest = ack_out_tdest;
    chk("stall_data0", hold_data, 64'h0701);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_data", ack_out_tdata, hold_data);
      chk("stall_dest", ack_out_tdest, hold_dest);
      chk("stall_tready", cmd_in_tready, 0);
    end
    @(posedge clk); #1;
    ack_out_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_release_tvalid", ack_out_tvalid, 0);
    chk("stall_release_tready", cmd_in_tready, 1);
    chk("stall_cnt", locked_count, 2);
    @(posedge clk); #1;

    // Range boundary and unknown command
    send(8'h04, 8'd20, 4'd1); idle(4);
    chk("lk20_data", last_data, 64'h1400); chk("lk20_err", err_cnt, 2);
    send(8'h04, 8'd15, 4'd4); idle(4);
    chk("lk15_data", last_data, 64'h0F01); chk("lk15_cnt", locked_count, 3);
    send(8'h04, 8'd16, 4'd4); idle(4);
    chk("lk16_data", last_data, 64'h1000); chk("lk16_err", err_cnt, 3);
    acks_before = ack_cnt;
    send(8'h09, 8'd3, 4'd0); idle(3);
    chk("cmd09_err", err_cnt, 4); chk("cmd09_acks", ack_cnt, acks_before);

    // Back-to-back unlock throughput with illegal unlock afterwards
    send(8'h06, 8'd15, 4'd4);
    send(8'h06, 8'd15, 4'd4);
    idle(3);
    chk("b2b_cnt", locked_count, 2); chk("b2b_err", err_cnt, 5);
    send(8'h04, 8'd15, 4'd4); idle(4);
    chk("relk15_cnt", locked_count, 3);

    // Reset while an ack is pending with three locks held
    ack_out_tready = 1'b0;
    send(8'h04, 8'd5, 4'd0);
    wait_valid();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tvalid", ack_out_tvalid, 0);
    chk("midrst_cnt", locked_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ack_out_tready = 1'b1;
    acks_before = ack_cnt;
    send(8'h04, 8'd5, 4'd6); idle(4);
    chk("postrst_data", last_data, 64'h0501); chk("postrst_dest", last_dest, 6);
    chk("postrst_acks", ack_cnt, acks_before + 1); chk("postrst_cnt", locked_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lock_manager.md
LOCK_MANAGER -- requirements
Module: lock_manager

Interface
REQ-001 SHALL have parameter NUM_LOCKS, default 256, number of lock slots implemented (1..256).
REQ-002 SHALL have parameter ACC_BITS, default 4, width of accelerator id fields.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port cmd_in_tdata, input, 64, command word: [7:0] cmd type, [15:8] lock id.
REQ-006 SHALL have port cmd_in_tvalid, input, 1, command valid.
REQ-007 SHALL have port cmd_in_tready, output, 1, command accepted when high with tvalid.
REQ-008 SHALL have port cmd_in_tid, input, ACC_BITS, issuing accelerator id.
REQ-009 SHALL have port ack_out_tdata, output, 64, ack word: [7:0] ack code, [15:8] lock id echo, [63:16] zero.
REQ-010 SHALL have port ack_out_tvalid, output, 1, ack valid.
REQ-011 SHALL have port ack_out_tready, input, 1, ack consumer ready.
REQ-012 SHALL have port ack_out_tdest, output, ACC_BITS, destination accelerator id.
REQ-013 SHALL have port locked_count, output, 9, number of currently held locks.
REQ-014 SHALL have port err_pulse, output, 1, one-cycle pulse on an illegal command.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, ACK; reset state IDLE.
REQ-016 cmd_in_tready SHALL be high only in IDLE; handshake in IDLE moves to EXEC and registers tdata[15:0] and tid.
REQ-017 In EXEC, LOCK (cmd 8'h04) on a free slot with id < NUM_LOCKS SHALL set the slot busy, record tid as owner, and prepare ack code 8'h01 (OK).
REQ-018 In EXEC, LOCK on a busy slot SHALL leave state unchanged and prepare ack code 8'h00 (REJECT); the owner re-requesting also gets REJECT.
REQ-019 In EXEC, LOCK with id >= NUM_LOCKS SHALL prepare REJECT and pulse err_pulse.
REQ-020 LOCK in EXEC SHALL move to ACK; ack_out_tvalid asserts the cycle after EXEC (2 cycles after the accept cycle).
REQ-021 In EXEC, UNLOCK (cmd 8'h06) on a busy slot owned by tid SHALL free the slot; no ack is generated; next state IDLE.
REQ-022 UNLOCK of a free slot, by a non-owner, or with id >= NUM_LOCKS SHALL change nothing, pulse err_pulse, generate no ack, return to IDLE.
REQ-023 Any other cmd type SHALL be dropped with err_pulse and no ack; next state IDLE.
REQ-024 In ACK, ack_out_tdata/tdest SHALL hold stable while tvalid is high and tready is low; on handshake, next state IDLE.
REQ-025 locked_count SHALL increment on a grant and decrement on a free in the same EXEC cycle as the table update; range 0..NUM_LOCKS, never wraps.
REQ-026 err_pulse SHALL be high for exactly the EXEC cycle of the offending command.
REQ-027 Throughput SHALL be one command per 2 cycles (unlock/illegal) or 3 cycles minimum (lock, ack taken immediately).

Reset
REQ-028 On rst: state IDLE, all slots free, owners zero, locked_count 0, cmd_in_tready 0 during rst, ack_out_tvalid 0, ack_out_tdata 0, ack_out_tdest 0, err_pulse 0.
REQ-029 rst asserted mid-operation SHALL discard any pending ack and free all locks; first accept possible the cycle after rst deasserts.

Structure
REQ-030 Shared package SHALL hold cmd codes (CMD_LOCK_CODE, CMD_UNLOCK_CODE), LOCK_ID_L/H, LOCK_ID_BITS, ACK_OK/REJECT codes, and new ACK_LOCKID_L=8, ACK_LOCKID_H=15, LOCK_NUM_DEFAULT=256.
REQ-031 Slot busy flags and owner ids SHALL live in one sub-module lock_table (1-cycle registered update, combinational read by lock id).

Verification
REQ-032 LOCK id 5 from acc 2 -> ack tdata[7:0]=01, [15:8]=05, tdest=2 two cycles after accept; locked_count=1.
REQ-033 Then LOCK id 5 from acc 3 -> ack 00, tdest=3; locked_count stays 1; UNLOCK id 5 from acc 3 -> err_pulse, lock still held.
REQ-034 UNLOCK id 5 from acc 2 -> no ack, locked_count=0; following LOCK id 5 from acc 3 -> ack 01.
REQ-035 ack_out_tready low 10 cycles during ACK -> tdata/tdest stable, cmd_in_tready low throughout; tready high -> IDLE next cycle.
REQ-036 NUM_LOCKS=16, LOCK id 20 -> ack 00 plus err_pulse; cmd 8'h09 -> err_pulse, no ack.
REQ-037 rst during ACK with 3 locks held -> tvalid 0, locked_count 0, subsequent LOCK on a previously held id -> ack 01.
